// File: rtl/ps2_key_controller.sv
// PS/2 set-2 scancode sequencer: held-key state for two Pong paddles plus a serve strobe.
// Optional macro KEYCTL_LAST_WINS_EN: with both directions held, the most recent press wins (else cancel).
module ps2_key_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter logic [7:0]  P1_UP_CODE     = 8'h1D,
   parameter logic [7:0]  P1_DN_CODE     = 8'h1B,
   parameter logic [7:0]  P2_UP_CODE     = 8'h75,
   parameter logic [7:0]  P2_DN_CODE     = 8'h72,
   parameter logic [7:0]  SERVE_CODE     = 8'h29
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       p1_up,
   output logic       p1_down,
   output logic       p2_up,
   output logic       p2_down,
   output logic       serve_pulse,
   output logic       err_pulse
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt;
   logic          p1u_h, p1d_h, p2u_h, p2d_h, srv_h;
   logic          p1u_n, p1d_n, p2u_n, p2d_n, srv_n;
   logic          serve_n, err_n, dec, ext, brk, make;
   logic [1:0]    p1_res, p2_res;

`ifdef KEYCTL_LAST_WINS_EN
   // Priority bit = 1 when the down key was the most recent fresh press.
   logic p1_prio, p2_prio, p1_prio_n, p2_prio_n;

   function automatic logic [1:0] resolve(input logic up, input logic dn, input logic prio);
      if (up && dn) return prio ? 2'b01 : 2'b10;
      return {up, dn};
   endfunction

   assign p1_res = resolve(p1u_n, p1d_n, p1_prio_n);
   assign p2_res = resolve(p2u_n, p2d_n, p2_prio_n);
`else
   function automatic logic [1:0] resolve(input logic up, input logic dn);
      if (up && dn) return 2'b00;
      return {up, dn};
   endfunction

   assign p1_res = resolve(p1u_n, p1d_n);
   assign p2_res = resolve(p2u_n, p2d_n);
`endif

   always_comb begin
      state_n = state;
      p1u_n   = p1u_h;
      p1d_n   = p1d_h;
      p2u_n   = p2u_h;
      p2d_n   = p2d_h;
      srv_n   = srv_h;
`ifdef KEYCTL_LAST_WINS_EN
      p1_prio_n = p1_prio;
      p2_prio_n = p2_prio;
`endif
      serve_n = 1'b0;
      err_n   = 1'b0;
      dec     = 1'b0;
      ext     = (state == EXT) || (state == EXT_BRK);
      brk     = (state == BRK) || (state == EXT_BRK);
      make    = !brk;

      if (byte_valid) begin
         case (byte_data)
            8'h00, 8'hFF: begin
               p1u_n   = 1'b0;
               p1d_n   = 1'b0;
               p2u_n   = 1'b0;
               p2d_n   = 1'b0;
               srv_n   = 1'b0;
`ifdef KEYCTL_LAST_WINS_EN
               p1_prio_n = 1'b0;
               p2_prio_n = 1'b0;
`endif
               state_n = IDLE;
               err_n   = 1'b1;
            end
            8'hAA, 8'hFA, 8'hFE: state_n = IDLE;
            8'hE0:               state_n = EXT;
            8'hF0:               state_n = ext ? EXT_BRK : BRK;
            default: begin
               state_n = IDLE;
               dec     = 1'b1;
            end
         endcase
      end else if (state != IDLE && cnt == CNT_MAX) begin
         state_n = IDLE;
         err_n   = 1'b1;
      end

      if (dec) begin
         if (!ext) begin
            if (byte_data == P1_UP_CODE) begin
`ifdef KEYCTL_LAST_WINS_EN
               if (make && !p1u_h) p1_prio_n = 1'b0;
`endif
               p1u_n = make;
            end else if (byte_data == P1_DN_CODE) begin
`ifdef KEYCTL_LAST_WINS_EN
               if (make && !p1d_h) p1_prio_n = 1'b1;
`endif
               p1d_n = make;
            end else if (byte_data == SERVE_CODE) begin
               serve_n = make && !srv_h;
               srv_n   = make;
            end
         end else begin
            if (byte_data == P2_UP_CODE) begin
`ifdef KEYCTL_LAST_WINS_EN
               if (make && !p2u_h) p2_prio_n = 1'b0;
`endif
               p2u_n = make;
            end else if (byte_data == P2_DN_CODE) begin
`ifdef KEYCTL_LAST_WINS_EN
               if (make && !p2d_h) p2_prio_n = 1'b1;
`endif
               p2d_n = make;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         p1u_h       <= 1'b0;
         p1d_h       <= 1'b0;
         p2u_h       <= 1'b0;
         p2d_h       <= 1'b0;
         srv_h       <= 1'b0;
`ifdef KEYCTL_LAST_WINS_EN
         p1_prio     <= 1'b0;
         p2_prio     <= 1'b0;
`endif
         p1_up       <= 1'b0;
         p1_down     <= 1'b0;
         p2_up       <= 1'b0;
         p2_down     <= 1'b0;
         serve_pulse <= 1'b0;
         err_pulse   <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= (byte_valid || state_n == IDLE) ? '0 : cnt + CW'(1);
         p1u_h       <= p1u_n;
         p1d_h       <= p1d_n;
         p2u_h       <= p2u_n;
         p2d_h       <= p2d_n;
         srv_h       <= srv_n;
`ifdef KEYCTL_LAST_WINS_EN
         p1_prio     <= p1_prio_n;
         p2_prio     <= p2_prio_n;
`endif
         // Outputs resolve from next-state held bits so they track the byte's own edge.
         {p1_up, p1_down} <= p1_res;
         {p2_up, p2_down} <= p2_res;
         serve_pulse <= serve_n;
         err_pulse   <= err_n;
      end
   end

endmodule

// File: tb/tb_ps2_key_controller.sv
// Randomized + directed bench for ps2_key_controller against a prefix-flag/key-table model.
module tb_ps2_key_controller;

   localparam int unsigned T = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       p1_up, p1_down, p2_up, p2_down, serve_pulse, err_pulse;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   ps2_key_controller #(
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk),
      .rst(rst),
      .byte_valid(byte_valid),
      .byte_data(byte_data),
      .p1_up(p1_up),
      .p1_down(p1_down),
      .p2_up(p2_up),
      .p2_down(p2_down),
      .serve_pulse(serve_pulse),
      .err_pulse(err_pulse)
   );

   task automatic check(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Reference model: pending prefix flags, key table, last-press memory.
   logic [7:0] key_code [5] = '{8'h1D, 8'h1B, 8'h75, 8'h72, 8'h29};
   logic       key_ext  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic       held [5];
   logic       last_dn [2];
   logic       pend_ext, pend_brk;
   longint     cyc, last_byte_cyc;
   logic       m_serve, m_err;

   function automatic logic [1:0] arb(input logic up, input logic dn, input logic ldn);
      if (up && dn) begin
`ifdef KEYCTL_LAST_WINS_EN
         return ldn ? 2'b01 : 2'b10;
`else
         return 2'b00;
`endif
      end
      return {up && !dn, dn && !up};
   endfunction

   task automatic model_clear_all();
      for (int i = 0; i < 5; i++) held[i] = 1'b0;
      last_dn[0] = 1'b0;
      last_dn[1] = 1'b0;
      pend_ext = 1'b0;
      pend_brk = 1'b0;
   endtask

   task automatic model_key(input logic [7:0] d, input logic e, input logic b);
      for (int i = 0; i < 5; i++) begin
         if (key_code[i] == d && key_ext[i] == e) begin
            if (!b) begin
               if (!held[i]) begin
                  if (i < 4) last_dn[i/2] = (i % 2 == 1);
                  else m_serve = 1'b1;
               end
               held[i] = 1'b1;
            end else begin
               held[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic model_step(input logic r, input logic v, input logic [7:0] d);
      cyc++;
      m_serve = 1'b0;
      m_err   = 1'b0;
      if (r) begin
         model_clear_all();
         last_byte_cyc = cyc;
      end else if (v) begin
         last_byte_cyc = cyc;
         if (d == 8'h00 || d == 8'hFF) begin
            model_clear_all();
            m_err = 1'b1;
         end else if (d == 8'hAA || d == 8'hFA || d == 8'hFE) begin
            pend_ext = 1'b0;
            pend_brk = 1'b0;
         end else if (d == 8'hE0) begin
            pend_ext = 1'b1;
            pend_brk = 1'b0;
         end else if (d == 8'hF0) begin
            pend_brk = 1'b1;
         end else begin
            model_key(d, pend_ext, pend_brk);
            pend_ext = 1'b0;
            pend_brk = 1'b0;
         end
      end else if ((pend_ext || pend_brk) && (cyc - last_byte_cyc == longint'(T))) begin
         pend_ext = 1'b0;
         pend_brk = 1'b0;
         m_err = 1'b1;
      end
   endtask

   initial begin
      logic [1:0] r1, r2;
      cyc = 0;
      last_byte_cyc = 0;
      model_clear_all();
      forever begin
         @(posedge clk);
         model_step(rst, byte_valid, byte_data);
         #1;
         r1 = arb(held[0], held[1], last_dn[0]);
         r2 = arb(held[2], held[3], last_dn[1]);
         check("p1_up",       p1_up,       r1[1]);
         check("p1_down",     p1_down,     r1[0]);
         check("p2_up",       p2_up,       r2[1]);
         check("p2_down",     p2_down,     r2[0]);
         check("serve_pulse", serve_pulse, m_serve);
         check("err_pulse",   err_pulse,   m_err);
      end
   end

   // Called at a negedge; byte sampled on the next posedge; returns at the following negedge.
   task automatic send(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h75, 8'h72, 8'h29,
                             8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h29};

   initial begin
      rst = 1'b1;
      byte_valid = 1'b0;
      byte_data = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_p1_up", p1_up, 1'b0);
      check("rst_p2_down", p2_down, 1'b0);
      check("rst_serve", serve_pulse, 1'b0);
      check("rst_err", err_pulse, 1'b0);

      send(8'h1D);                 check("t1_make", p1_up, 1'b1);
      send(8'hF0); send(8'h1D);    check("t1_break", p1_up, 1'b0);

      send(8'hE0); send(8'h75);    check("t2_make", p2_up, 1'b1);
      send(8'hE0); send(8'hF0); send(8'h75); check("t2_break", p2_up, 1'b0);
      send(8'h75);                 check("t2_bare_up", p2_up, 1'b0);
      check("t2_bare_dn", p2_down, 1'b0);

      send(8'h1D); send(8'h1B);
`ifdef KEYCTL_LAST_WINS_EN
      check("t3_both_dn", p1_down, 1'b1);
      check("t3_both_up", p1_up, 1'b0);
`else
      check("t3_both_dn", p1_down, 1'b0);
      check("t3_both_up", p1_up, 1'b0);
`endif
      send(8'hF0); send(8'h1B);    check("t3_handback", p1_up, 1'b1);
      check("t3_handback_dn", p1_down, 1'b0);
      send(8'hF0); send(8'h1D);

      send(8'h29);                 check("t4_serve1", serve_pulse, 1'b1);
      send(8'h29);                 check("t4_rep1", serve_pulse, 1'b0);
      send(8'h29);                 check("t4_rep2", serve_pulse, 1'b0);
      send(8'hF0); send(8'h29);    check("t4_brk", serve_pulse, 1'b0);
      send(8'h29);                 check("t4_serve2", serve_pulse, 1'b1);
      send(8'hF0); send(8'h29);

      send(8'hF0);
      repeat (T - 1) @(negedge clk);
      check("t5_pre_to", err_pulse, 1'b0);
      @(negedge clk);              check("t5_timeout", err_pulse, 1'b1);
      @(negedge clk);              check("t5_to_end", err_pulse, 1'b0);
      send(8'h1B);                 check("t5_make_after", p1_down, 1'b1);
      send(8'hF0);
      repeat (T - 1) @(negedge clk);
      send(8'h1B);                 check("t5_byte_wins_err", err_pulse, 1'b0);
      check("t5_byte_wins_brk", p1_down, 1'b0);

      send(8'h1D); send(8'hE0); send(8'h72);
      check("t6_p1", p1_up, 1'b1);
      check("t6_p2", p2_down, 1'b1);
      send(8'hFF);
      check("t6_err", err_pulse, 1'b1);
      check("t6_p1_clr", p1_up, 1'b0);
      check("t6_p2_clr", p2_down, 1'b0);
      send(8'hF0); pulse_rst();
      send(8'h1D);                 check("t6_rst_make", p1_up, 1'b1);
      send(8'hF0); send(8'h1D);

      for (int i = 0; i < 3000; i++) begin
         int unsigned sel;
         sel = $urandom_range(0, 99);
         if (sel < 1) pulse_rst();
         else if (sel < 3) send(($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF);
         else if (sel < 6) send(($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFE);
         else if (sel < 10) send(8'($urandom_range(0, 255)));
         else send(pool[$urandom_range(0, 11)]);
         if ($urandom_range(0, 14) == 0) repeat ($urandom_range(T - 2, T + 8)) @(negedge clk);
         else repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
